// File: rtl/word_serializer.sv
// ---------------------------------------------------------------------------
// word_serializer
//
// Parallel-in, serial-out transmitter for the 32-bit serial word link.
// It accepts one word ahead into a holding register, then shifts it out MSB
// first. The receiver shifts bits in from the LSB side, so it reassembles
// the original word.
//
// Ports
//   clk         rising-edge clock for all state
//   reset       asynchronous, active-low reset
//   word_in     parallel word offered by the upstream block
//   word_valid  word_in is valid
//   word_ready  holding register is empty and can accept a word
//   bit_ready   downstream accepts the current bit this cycle
//   serial_out  current bit (shifter MSB), 0 when not shifting
//   shift_en    serial_out is valid (receiver shift enable)
//   last_bit    current bit is bit 0 of the word
//   done_word   one-cycle pulse after a word's last bit is transferred
//   busy        shifter or holding register occupied
// ---------------------------------------------------------------------------
module word_serializer #(
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] word_in,
  input  logic             word_valid,
  output logic             word_ready,
  input  logic             bit_ready,
  output logic             serial_out,
  output logic             shift_en,
  output logic             last_bit,
  output logic             done_word,
  output logic             busy
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  logic [0:0]       state_q,     state_d;
  logic [WIDTH-1:0] shift_q,     shift_d;
  logic [WIDTH-1:0] hold_q,      hold_d;
  logic             hold_full_q, hold_full_d;
  logic [CNT_W-1:0] cnt_q,       cnt_d;
  logic             done_q,      done_d;

  logic accept;
  logic transfer;
  logic at_last;

  assign shift_en   = (state_q == ST_SHIFT);
  assign at_last    = (cnt_q == CNT_LAST);
  assign transfer   = shift_en && bit_ready;
  assign word_ready = !hold_full_q;
  // The holding register only refills while it is empty, so an accept can
  // never coincide with the shifter draining it.
  assign accept     = word_valid && !hold_full_q;

  assign serial_out = shift_en && shift_q[WIDTH-1];
  assign last_bit   = shift_en && at_last;
  assign done_word  = done_q;
  assign busy       = shift_en || hold_full_q;

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    state_d     = state_q;
    shift_d     = shift_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    cnt_d       = cnt_q;
    done_d      = 1'b0;

    if (accept) begin
      hold_d      = word_in;
      hold_full_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (hold_full_q) begin
          shift_d     = hold_q;
          hold_full_d = 1'b0;
          cnt_d       = '0;
          state_d     = ST_SHIFT;
        end
      end
      default: begin
        if (transfer) begin
          if (!at_last) begin
            shift_d = shift_q << 1;
            cnt_d   = cnt_q + CNT_W'(1);
          end else begin
            done_d = 1'b1;
            // Reload straight from the holding register so back-to-back
            // words go out without an idle bubble between them.
            if (hold_full_q) begin
              shift_d     = hold_q;
              hold_full_d = 1'b0;
              cnt_d       = '0;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of its inputs regardless of block ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      shift_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      cnt_q       <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      cnt_q       <= cnt_d;
      done_q      <= done_d;
    end
  end

endmodule

// File: tb/tb_word_serializer.sv
// ---------------------------------------------------------------------------
// tb_word_serializer
//
// Self-checking bench for word_serializer. A word-level model (a queue for
// the holding register, the word in flight plus a bit index) predicts every
// output each cycle, and a loop-back receiver rebuilds the serial stream and
// compares every completed word against the accepted-word queue. Directed
// scenarios add hand-computed literal expectations; a randomized phase
// follows.
// ---------------------------------------------------------------------------
module tb_word_serializer;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] word_in;
  logic         word_valid;
  logic         word_ready;
  logic         bit_ready;
  logic         serial_out;
  logic         shift_en;
  logic         last_bit;
  logic         done_word;
  logic         busy;

  word_serializer #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .word_in   (word_in),
    .word_valid(word_valid),
    .word_ready(word_ready),
    .bit_ready (bit_ready),
    .serial_out(serial_out),
    .shift_en  (shift_en),
    .last_bit  (last_bit),
    .done_word (done_word),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ------------------------------------------------------------------
  // Word-level model
  // ------------------------------------------------------------------
  logic [W-1:0] m_hold[$];   // at most one buffered word
  logic [W-1:0] exp_q[$];    // every accepted word, in order
  logic         m_cur_valid;
  logic [W-1:0] m_cur;
  int           m_idx;       // bits of m_cur already sent
  logic         m_done;
  logic         m_accepted;
  int           m_acc_total = 0;

  task automatic model_reset();
    m_hold.delete();
    exp_q.delete();
    m_cur_valid = 1'b0;
    m_cur       = '0;
    m_idx       = 0;
    m_done      = 1'b0;
    m_accepted  = 1'b0;
  endtask

  // Advance the model by one clock edge using the inputs that were stable
  // before the edge.
  task automatic model_step();
    logic xfer;
    logic acc;
    m_accepted = 1'b0;
    if (!reset) return;
    xfer   = m_cur_valid && bit_ready;
    acc    = word_valid && (m_hold.size() == 0);
    m_done = xfer && (m_idx == W - 1);
    if (m_cur_valid) begin
      if (xfer) begin
        if (m_idx < W - 1) m_idx++;
        else if (m_hold.size() != 0) begin
          m_cur = m_hold.pop_front();
          m_idx = 0;
        end else m_cur_valid = 1'b0;
      end
    end else if (m_hold.size() != 0) begin
      m_cur       = m_hold.pop_front();
      m_idx       = 0;
      m_cur_valid = 1'b1;
    end
    if (acc) begin
      m_hold.push_back(word_in);
      exp_q.push_back(word_in);
      m_accepted = 1'b1;
      m_acc_total++;
    end
  endtask

  // ------------------------------------------------------------------
  // Per-cycle compare, loop-back receiver and scenario statistics
  // ------------------------------------------------------------------
  logic [W-1:0] rx;
  logic [W-1:0] st_rx;
  logic         st_started;
  logic         st_first_br;
  int           st_cyc, st_shift, st_last_shift, st_last_idx, st_last_cnt;
  int           st_done, st_xfer;
  int           st_done_pos[4];

  task automatic clear_stats();
    st_started    = 1'b0;
    st_first_br   = 1'b0;
    st_cyc        = 0;
    st_shift      = 0;
    st_last_shift = 0;
    st_last_idx   = 0;
    st_last_cnt   = 0;
    st_done       = 0;
    st_xfer       = 0;
    st_rx         = '0;
    for (int i = 0; i < 4; i++) st_done_pos[i] = 0;
  endtask

  always @(negedge clk) begin
    check("shift_en",   shift_en,   m_cur_valid);
    check("serial_out", serial_out, m_cur_valid ? m_cur[W-1-m_idx] : 1'b0);
    check("last_bit",   last_bit,   m_cur_valid && (m_idx == W - 1));
    check("done_word",  done_word,  m_done);
    check("busy",       busy,       m_cur_valid || (m_hold.size() != 0));
    check("word_ready", word_ready, m_hold.size() == 0);

    if (shift_en && !st_started) begin
      st_started  = 1'b1;
      st_first_br = bit_ready;
    end
    if (st_started) st_cyc++;
    if (shift_en) begin
      st_shift++;
      st_last_shift = st_cyc;
    end
    if (last_bit) begin
      st_last_idx = st_cyc;
      st_last_cnt++;
    end
    if (done_word) begin
      if (st_done < 4) st_done_pos[st_done] = st_cyc;
      st_done++;
    end
    if (shift_en && bit_ready) begin
      st_xfer++;
      rx = {rx[W-2:0], serial_out};
      if (last_bit) begin
        st_rx = rx;
        check("rx_pending", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) check("rx_word", rx, exp_q.pop_front());
      end
    end
  end

  // ------------------------------------------------------------------
  // Stimulus helpers
  // ------------------------------------------------------------------
  int br_mode = 0;   // 0: always ready, 1: toggle every cycle, 2: random

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    case (br_mode)
      1:       bit_ready = ~bit_ready;
      2:       bit_ready = ($urandom_range(0, 3) != 0);
      default: bit_ready = 1'b1;
    endcase
  endtask

  task automatic offer(input logic [W-1:0] w, output int waited);
    word_in    = w;
    word_valid = 1'b1;
    waited     = 0;
    do begin
      tick();
      waited++;
    end while (!m_accepted && waited < 2000);
    check("offer_accepted", m_accepted, 1'b1);
    word_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((m_cur_valid || m_hold.size() != 0 || m_done) && n < 5000) begin
      tick();
      n++;
    end
    check("idle_reached", busy, 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_serial_out"}, serial_out, 1'b0);
    check({tag, "_shift_en"},   shift_en,   1'b0);
    check({tag, "_last_bit"},   last_bit,   1'b0);
    check({tag, "_done_word"},  done_word,  1'b0);
    check({tag, "_busy"},       busy,       1'b0);
    check({tag, "_word_ready"}, word_ready, 1'b1);
  endtask

  // ------------------------------------------------------------------
  // Scenarios
  // ------------------------------------------------------------------
  initial begin
    int waited;
    int acc0;
    int done0;

    reset      = 1'b0;
    word_in    = '0;
    word_valid = 1'b0;
    bit_ready  = 1'b1;
    rx         = '0;
    model_reset();
    clear_stats();
    #1;
    check_reset_outputs("por");
    repeat (3) tick();
    reset = 1'b1;
    repeat (2) tick();

    // Single word, bit_ready held high.
    clear_stats();
    offer(32'hA500_0001, waited);
    wait_idle();
    check("single_shift_cycles", st_shift,       32);
    check("single_last_shift",   st_last_shift,  32);
    check("single_last_idx",     st_last_idx,    32);
    check("single_last_cnt",     st_last_cnt,    1);
    check("single_done_cnt",     st_done,        1);
    check("single_done_pos",     st_done_pos[0], 33);
    check("single_rx",           st_rx,          32'hA500_0001);

    // Back-to-back words: no gap between them.
    clear_stats();
    offer(32'hDEAD_BEEF, waited);
    offer(32'h1234_5678, waited);
    wait_idle();
    check("b2b_shift_cycles", st_shift,       64);
    check("b2b_last_shift",   st_last_shift,  64);
    check("b2b_done_cnt",     st_done,        2);
    check("b2b_done_pos0",    st_done_pos[0], 33);
    check("b2b_done_pos1",    st_done_pos[1], 65);
    check("b2b_rx",           st_rx,          32'h1234_5678);

    // Stall: bit_ready alternates every cycle.
    br_mode = 1;
    clear_stats();
    offer(32'hFFFF_0000, waited);
    wait_idle();
    check("stall_shift_cycles", st_shift, st_first_br ? 63 : 64);
    check("stall_xfers",        st_xfer,  32);
    check("stall_done_cnt",     st_done,  1);
    check("stall_rx",           st_rx,    32'hFFFF_0000);
    br_mode = 0;

    // Reset mid-word with a second word buffered.
    clear_stats();
    offer(32'h0F0F_0F0F, waited);
    offer(32'h3333_3333, waited);
    waited = 0;
    while (st_xfer < 10 && waited < 200) begin
      tick();
      waited++;
    end
    check("midrst_busy_before", busy, 1'b1);
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    check_reset_outputs("midrst");
    repeat (3) begin
      word_valid = 1'($urandom);
      word_in    = $urandom;
      tick();
      bit_ready  = 1'($urandom);
    end
    check_reset_outputs("midrst_held");
    word_valid = 1'b0;
    reset      = 1'b1;
    repeat (5) tick();
    check("midrst_no_done", st_done, 0);
    clear_stats();
    offer(32'h8000_0000, waited);
    wait_idle();
    check("post_rst_done_cnt", st_done, 1);
    check("post_rst_rx",       st_rx,   32'h8000_0000);

    // Full buffer: word_valid held while shifter and holding register are full.
    clear_stats();
    acc0 = m_acc_total;
    offer(32'hAAAA_5555, waited);
    offer(32'h5555_AAAA, waited);
    offer(32'h1111_1111, waited);
    check("full_waited", waited > 1, 1'b1);
    wait_idle();
    check("full_accepts",  m_acc_total - acc0, 3);
    check("full_done_cnt", st_done,            3);
    check("full_rx",       st_rx,              32'h1111_1111);
    check("full_exp_left", exp_q.size(),       0);

    // Randomized traffic with random downstream stalls.
    br_mode = 2;
    clear_stats();
    done0 = st_done;
    for (int i = 0; i < 150; i++) begin
      repeat ($urandom_range(0, 3)) tick();
      offer($urandom, waited);
    end
    wait_idle();
    check("rand_done_cnt", st_done - done0, 150);
    check("rand_exp_left", exp_q.size(),    0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
